// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
//
// Multi-port register file that sits between decode (read addresses) and
// writeback (write port). It has one byte-masked write port and two
// asynchronous read ports. Register 0 can be hardwired to zero, and a write
// can be forwarded to matching read ports in the same cycle.
//
// The array is never reset directly, so it can map onto RAM. A clear engine
// zeroes it instead, one entry per cycle. The engine runs after reset and
// whenever clearReq is seen in IDLE.
//
// Parameters
//   DATA_WIDTH  register width in bits (multiple of 8)
//   ADDR_WIDTH  register index width; NUM_REGS = 2**ADDR_WIDTH
//   ZERO_REG    1: register 0 reads as 0 and writes to it are discarded
//   BYPASS      1: an effective write is forwarded to matching read ports
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   clearReq   request a full zero sweep (sampled only in IDLE)
//   clearBusy  high while sweeping or while reset is asserted
//   wrEn       write strobe
//   wrAddr     write register index
//   wrData     write data
//   wrMask     byte enables; bit i covers bits 8i+7:8i
//   wrDropped  one-cycle pulse: a write was rejected because of a sweep
//   rdAddrA/B  read indices
//   rdDataA/B  combinational read data
// -----------------------------------------------------------------------------
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clearReq,
  output logic                    clearBusy,
  input  logic                    wrEn,
  input  logic [ADDR_WIDTH-1:0]   wrAddr,
  input  logic [DATA_WIDTH-1:0]   wrData,
  input  logic [DATA_WIDTH/8-1:0] wrMask,
  output logic                    wrDropped,
  input  logic [ADDR_WIDTH-1:0]   rdAddrA,
  input  logic [ADDR_WIDTH-1:0]   rdAddrB,
  output logic [DATA_WIDTH-1:0]   rdDataA,
  output logic [DATA_WIDTH-1:0]   rdDataB
);

  localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   sweep_idx, sweep_idx_next;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
  logic                    wr_eff;
  logic [DATA_WIDTH-1:0]   wr_merged;

  assign clearBusy = reset || (state == SWEEP);

  // A write commits only in IDLE and outside reset. A write to the hardwired
  // zero register is discarded without flagging it as dropped.
  assign wr_eff = wrEn && (state == IDLE) && !reset &&
                  !((ZERO_REG != 0) && (wrAddr == '0));

  // ---------------------------------------------------------------------------
  // Control state: the FSM, the sweep index and the dropped-write flag.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values, whatever order the processes run in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SWEEP;
      sweep_idx <= '0;
      wrDropped <= 1'b0;
    end else begin
      state     <= state_next;
      sweep_idx <= sweep_idx_next;
      // Outside reset, clearBusy can only come from a running sweep.
      wrDropped <= wrEn && (state == SWEEP);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    sweep_idx_next = sweep_idx;
    case (state)
      SWEEP: begin
        sweep_idx_next = sweep_idx + ADDR_WIDTH'(1);
        // The last entry is cleared on this edge. Leave before the index wraps.
        if (sweep_idx == '1) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (clearReq) begin
          state_next     = SWEEP;
          sweep_idx_next = '0;
        end
      end
      default: begin
        state_next     = SWEEP;
        sweep_idx_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage array. While sweeping, one entry is cleared each cycle. Otherwise
  // the write port does a byte-masked update.
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch on purpose. A reset term would stop
  // it mapping to RAM, so the sweep engine does the clearing instead.
  always_ff @(posedge clk) begin
    if (!reset && (state == SWEEP)) begin
      regs[sweep_idx] <= '0;
    end else if (wr_eff) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wrMask[b]) begin
          regs[wrAddr][8*b +: 8] <= wrData[8*b +: 8];
        end
      end
    end
  end

  // Stored value at the write address with the enabled bytes replaced. This
  // is the forwarded value when a read port matches the write port.
  always_comb begin
    wr_merged = regs[wrAddr];
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (wrMask[b]) begin
        wr_merged[8*b +: 8] = wrData[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports. Later assignments take priority: busy, then the zero
  // register, then forwarding, then the stored value.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdDataA = regs[rdAddrA];
    if ((BYPASS != 0) && wr_eff && (wrAddr == rdAddrA)) begin
      rdDataA = wr_merged;
    end
    if ((ZERO_REG != 0) && (rdAddrA == '0)) begin
      rdDataA = '0;
    end
    if (clearBusy) begin
      rdDataA = '0;
    end
  end

  always_comb begin
    rdDataB = regs[rdAddrB];
    if ((BYPASS != 0) && wr_eff && (wrAddr == rdAddrB)) begin
      rdDataB = wr_merged;
    end
    if ((ZERO_REG != 0) && (rdAddrB == '0)) begin
      rdDataB = '0;
    end
    if (clearBusy) begin
      rdDataB = '0;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// -----------------------------------------------------------------------------
// tb_register_file_mp
//
// Directed bench for register_file_mp. Two instances share every input:
//   dut      default parameters (ZERO_REG = 1, BYPASS = 1)
//   dut_alt  ZERO_REG = 0, BYPASS = 0
// Inputs change 1 time unit after the rising edge. Outputs are checked on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          clearReq;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic [3:0]    wrMask;
  logic [AW-1:0] rdAddrA, rdAddrB;

  logic          busy, dropped;
  logic [DW-1:0] rd_a, rd_b;
  logic          busy_alt, dropped_alt;
  logic [DW-1:0] rd_a_alt, rd_b_alt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .clearReq(clearReq), .clearBusy(busy),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .wrMask(wrMask),
    .wrDropped(dropped), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
    .rdDataA(rd_a), .rdDataB(rd_b)
  );

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0), .BYPASS(0)) dut_alt (
    .clk(clk), .reset(reset), .clearReq(clearReq), .clearBusy(busy_alt),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .wrMask(wrMask),
    .wrDropped(dropped_alt), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
    .rdDataA(rd_a_alt), .rdDataB(rd_b_alt)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; clearReq = 1'b0;
    wrEn = 1'b1; wrAddr = 4'd6; wrData = 32'hFFFF_FFFF; wrMask = 4'hF;
    rdAddrA = 4'd6; rdAddrB = 4'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (busy !== 1'b1 || busy_alt !== 1'b1) begin
        bad++; $display("FAIL reset_busy: got %b/%b want 1/1", busy, busy_alt);
      end
      total++; if (rd_a !== '0 || rd_a_alt !== '0) begin
        bad++; $display("FAIL reset_read: got %h/%h want 0", rd_a, rd_a_alt);
      end
      next_cycle();
    end
    reset = 1'b0; wrEn = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      rdAddrA = AW'(k - 1); rdAddrB = AW'(NR - k);
      @(negedge clk);
      total++; if (busy !== 1'b1 || busy_alt !== 1'b1) begin
        bad++; $display("FAIL post_reset_busy cycle %0d: got %b/%b want 1/1", k, busy, busy_alt);
      end
      total++; if (rd_a !== '0 || rd_b !== '0 || rd_a_alt !== '0 || rd_b_alt !== '0) begin
        bad++; $display("FAIL post_reset_read cycle %0d: got %h %h %h %h want 0", k, rd_a, rd_b, rd_a_alt, rd_b_alt);
      end
      if (k == 1) begin
        total++; if (dropped !== 1'b0 || dropped_alt !== 1'b0) begin
          bad++; $display("FAIL reset_no_drop: got %b/%b want 0/0", dropped, dropped_alt);
        end
      end
      next_cycle();
    end
    rdAddrA = 4'd6; rdAddrB = 4'd1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || busy_alt !== 1'b0) begin
      bad++; $display("FAIL idle_after_sweep: got %b/%b want 0/0", busy, busy_alt);
    end
    total++; if (rd_a !== '0 || rd_b_alt !== '0) begin
      bad++; $display("FAIL swept_read: got %h/%h want 0/0", rd_a, rd_b_alt);
    end
    next_cycle();
  endtask

  task automatic test_masked_write;
    wrEn = 1'b1; wrAddr = 4'd5; wrData = 32'hDEAD_BEEF; wrMask = 4'hF;
    rdAddrA = 4'd5; rdAddrB = 4'd5;
    @(negedge clk);
    total++; if (rd_a !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL bypass_full: got %h want deadbeef", rd_a);
    end
    total++; if (rd_a_alt !== 32'h0) begin
      bad++; $display("FAIL nobypass_full: got %h want 00000000", rd_a_alt);
    end
    next_cycle();
    wrData = 32'h0000_1234; wrMask = 4'h3;
    @(negedge clk);
    total++; if (rd_b !== 32'hDEAD_1234 || rd_a !== 32'hDEAD_1234) begin
      bad++; $display("FAIL bypass_masked: got %h/%h want dead1234", rd_a, rd_b);
    end
    total++; if (rd_b_alt !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL nobypass_masked: got %h want deadbeef", rd_b_alt);
    end
    next_cycle();
    wrEn = 1'b0;
    @(negedge clk);
    total++; if (rd_a !== 32'hDEAD_1234 || rd_a_alt !== 32'hDEAD_1234) begin
      bad++; $display("FAIL masked_stored: got %h/%h want dead1234", rd_a, rd_a_alt);
    end
    total++; if (dropped !== 1'b0) begin
      bad++; $display("FAIL masked_no_drop: got %b want 0", dropped);
    end
    next_cycle();
  endtask

  task automatic test_zero_reg;
    wrEn = 1'b1; wrAddr = 4'd0; wrData = 32'hFFFF_FFFF; wrMask = 4'hF;
    rdAddrA = 4'd0; rdAddrB = 4'd5;
    @(negedge clk);
    total++; if (rd_a !== 32'h0) begin
      bad++; $display("FAIL zero_reg_same_cycle: got %h want 00000000", rd_a);
    end
    total++; if (rd_a_alt !== 32'h0) begin
      bad++; $display("FAIL r0_nobypass_same_cycle: got %h want 00000000", rd_a_alt);
    end
    next_cycle();
    wrEn = 1'b0;
    @(negedge clk);
    total++; if (rd_a !== 32'h0) begin
      bad++; $display("FAIL zero_reg_after: got %h want 00000000", rd_a);
    end
    total++; if (dropped !== 1'b0) begin
      bad++; $display("FAIL zero_reg_no_drop: got %b want 0", dropped);
    end
    total++; if (rd_a_alt !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL r0_writable: got %h want ffffffff", rd_a_alt);
    end
    next_cycle();
  endtask

  task automatic test_bypass_off;
    wrEn = 1'b1; wrAddr = 4'd7; wrData = 32'h0000_0055; wrMask = 4'hF;
    rdAddrA = 4'd7;
    @(negedge clk);
    total++; if (rd_a_alt !== 32'h0) begin
      bad++; $display("FAIL nobypass_old_value: got %h want 00000000", rd_a_alt);
    end
    total++; if (rd_a !== 32'h0000_0055) begin
      bad++; $display("FAIL bypass_new_value: got %h want 00000055", rd_a);
    end
    next_cycle();
    wrEn = 1'b0;
    @(negedge clk);
    total++; if (rd_a_alt !== 32'h0000_0055 || rd_a !== 32'h0000_0055) begin
      bad++; $display("FAIL r7_stored: got %h/%h want 00000055", rd_a, rd_a_alt);
    end
    next_cycle();
  endtask

  task automatic test_clear_req;
    clearReq = 1'b1;
    wrEn = 1'b1; wrAddr = 4'd3; wrData = 32'h0000_0007; wrMask = 4'hF;
    rdAddrA = 4'd3; rdAddrB = 4'd5;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL clear_req_cycle_busy: got %b want 0", busy);
    end
    total++; if (rd_a !== 32'h0000_0007) begin
      bad++; $display("FAIL clear_req_write_fwd: got %h want 00000007", rd_a);
    end
    next_cycle();
    for (int k = 1; k <= NR; k++) begin
      clearReq = (k == 5);
      wrEn = (k == 1);
      wrAddr = 4'd4; wrData = 32'h0000_0009;
      @(negedge clk);
      total++; if (busy !== 1'b1 || busy_alt !== 1'b1) begin
        bad++; $display("FAIL sweep_busy cycle %0d: got %b/%b want 1/1", k, busy, busy_alt);
      end
      total++; if (rd_a !== '0 || rd_b_alt !== '0) begin
        bad++; $display("FAIL sweep_read cycle %0d: got %h/%h want 0", k, rd_a, rd_b_alt);
      end
      total++; if (dropped !== (k == 2) || dropped_alt !== (k == 2)) begin
        bad++; $display("FAIL sweep_dropped cycle %0d: got %b/%b want %b", k, dropped, dropped_alt, (k == 2));
      end
      next_cycle();
    end
    clearReq = 1'b0; wrEn = 1'b0;
    rdAddrA = 4'd3; rdAddrB = 4'd4;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL sweep_end: got %b want 0", busy);
    end
    total++; if (rd_a !== '0 || rd_b !== '0 || rd_a_alt !== '0 || rd_b_alt !== '0) begin
      bad++; $display("FAIL swept_r3_r4: got %h %h %h %h want 0", rd_a, rd_b, rd_a_alt, rd_b_alt);
    end
    next_cycle();
    rdAddrA = 4'd5; rdAddrB = 4'd7;
    @(negedge clk);
    total++; if (rd_a !== '0 || rd_b !== '0 || rd_a_alt !== '0) begin
      bad++; $display("FAIL swept_r5_r7: got %h %h %h want 0", rd_a, rd_b, rd_a_alt);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_sweep;
    clearReq = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL mid_req_busy: got %b want 0", busy);
    end
    next_cycle();
    clearReq = 1'b0;
    // Sweep cycle k works on index k-1, so cycle 10 is index 9.
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      total++; if (busy !== 1'b1) begin
        bad++; $display("FAIL mid_sweep_busy cycle %0d: got %b want 1", k, busy);
      end
      next_cycle();
    end
    reset = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b1 || dropped !== 1'b0) begin
      bad++; $display("FAIL mid_reset: busy %b dropped %b want 1 0", busy, dropped);
    end
    next_cycle();
    reset = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      @(negedge clk);
      total++; if (busy !== 1'b1 || busy_alt !== 1'b1) begin
        bad++; $display("FAIL restart_busy cycle %0d: got %b/%b want 1/1", k, busy, busy_alt);
      end
      next_cycle();
    end
    wrEn = 1'b1; wrAddr = 4'd2; wrData = 32'h1122_3344; wrMask = 4'hC;
    rdAddrA = 4'd2;
    @(negedge clk);
    total++; if (busy !== 1'b0 || busy_alt !== 1'b0) begin
      bad++; $display("FAIL restart_end: got %b/%b want 0/0", busy, busy_alt);
    end
    total++; if (rd_a !== 32'h1122_0000) begin
      bad++; $display("FAIL restart_fwd: got %h want 11220000", rd_a);
    end
    next_cycle();
    wrEn = 1'b0;
    @(negedge clk);
    total++; if (rd_a !== 32'h1122_0000 || rd_a_alt !== 32'h1122_0000 || dropped !== 1'b0) begin
      bad++; $display("FAIL restart_write: got %h/%h dropped %b want 11220000 0", rd_a, rd_a_alt, dropped);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_zero_reg();
    test_bypass_off();
    test_clear_req();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
